// File: rtl/pulse_noise_gen.sv
`default_nettype none
// pulse_noise_gen: rectangular pulse train plus scaled Galois-LFSR noise behind a 2-stage valid/ready pipeline.
// Define PULSE_NOISE_GEN_SATURATE_EN to clamp samples to [0,65535]; otherwise samples wrap mod 2^16.
module pulse_noise_gen #(
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468,
  parameter int          W_SAMP    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [31:0]       pulse_period,
  input  logic [15:0]       pulse_width,
  input  logic [15:0]       pulse_amplitude,
  input  logic [15:0]       noise_amplitude,
  input  logic              sample_ready,
  output logic              sample_valid,
  output logic [W_SAMP-1:0] sample_data,
  output logic              pulse_active,
  output logic [31:0]       pulse_count,
  output logic              busy
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_RUN    = 2'd1;
  localparam logic [1:0]  ST_DRAIN  = 2'd2;
  localparam logic [31:0] SEED      = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  logic [1:0]         state;
  logic [31:0]        pos;
  logic [31:0]        lat_period;
  logic [15:0]        lat_width;
  logic [15:0]        lat_amp;
  logic [15:0]        lat_noise_amp;
  logic [31:0]        lfsr;

  logic               s1_valid;
  logic               s1_flag;
  logic [15:0]        s1_term;
  logic signed [17:0] s1_noise;

  logic               adv;
  logic               gen;
  logic               pos_zero;
  logic [31:0]        eff_period;
  logic [15:0]        eff_width;
  logic [15:0]        eff_amp;
  logic [15:0]        eff_noise_amp;
  logic               flag;
  logic [31:0]        pos_next;
  logic [31:0]        lfsr_next;
  logic signed [33:0] prod;
  logic signed [17:0] sum;
  logic [W_SAMP-1:0]  out_data;
  logic               unused_bits;

  assign adv      = !sample_valid || sample_ready;
  assign gen      = (state == ST_RUN) && enable && adv;
  assign pos_zero = (pos == 32'd0);
  assign busy     = (state != ST_IDLE);

  // The pos==0 sample already uses the fresh settings; later samples use the latched copy.
  assign eff_period    = pos_zero ? pulse_period    : lat_period;
  assign eff_width     = pos_zero ? pulse_width     : lat_width;
  assign eff_amp       = pos_zero ? pulse_amplitude : lat_amp;
  assign eff_noise_amp = pos_zero ? noise_amplitude : lat_noise_amp;

  assign flag     = (pos < {16'd0, eff_width});
  assign pos_next = ((eff_period <= 32'd1) || (pos == eff_period - 32'd1)) ? 32'd0 : pos + 32'd1;
  assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'd0);

  // Exact 33-bit product held in 34 bits; bits [33:16] are the arithmetic >>> 16.
  assign prod = $signed({{18{lfsr[15]}}, lfsr[15:0]}) * $signed({18'd0, eff_noise_amp});
  assign sum  = $signed({2'b00, s1_term}) + s1_noise;
  assign unused_bits = ^{prod[15:0], sum[17:16]};

`ifdef PULSE_NOISE_GEN_SATURATE_EN
  always_comb begin
    out_data = sum[15:0];
    if (sum[17]) begin
      out_data = '0;
    end else if (sum[16]) begin
      out_data = '1;
    end
  end
`else
  assign out_data = sum[15:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      pos           <= 32'd0;
      lat_period    <= 32'd0;
      lat_width     <= 16'd0;
      lat_amp       <= 16'd0;
      lat_noise_amp <= 16'd0;
      lfsr          <= SEED;
      pulse_count   <= 32'd0;
      s1_valid      <= 1'b0;
      s1_flag       <= 1'b0;
      s1_term       <= 16'd0;
      s1_noise      <= 18'sd0;
      sample_valid  <= 1'b0;
      sample_data   <= '0;
      pulse_active  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:  if (enable) state <= ST_RUN;
        ST_RUN:   if (!enable) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (enable) begin
            state <= ST_RUN;
          end else if (!s1_valid && adv) begin
            state <= ST_IDLE;
          end
        end
        default:  state <= ST_IDLE;
      endcase

      if (gen) begin
        pos      <= pos_next;
        lfsr     <= lfsr_next;
        s1_flag  <= flag;
        s1_term  <= flag ? eff_amp : 16'd0;
        s1_noise <= prod[33:16];
        if (pos_zero) begin
          lat_period    <= pulse_period;
          lat_width     <= pulse_width;
          lat_amp       <= pulse_amplitude;
          lat_noise_amp <= noise_amplitude;
          pulse_count   <= pulse_count + 32'd1;
        end
      end

      if (adv) begin
        s1_valid     <= gen;
        sample_valid <= s1_valid;
        if (s1_valid) begin
          sample_data  <= out_data;
          pulse_active <= s1_flag;
        end
      end
    end
  end

endmodule
`default_nettype wire
